// File: rtl/myniosiicpu_pio_pkg.sv
// Shared constants for the key PIO: the Avalon-MM register word addresses.
package myniosiicpu_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/myniosiicpu_debounce.sv
// One key: 2-flop synchronizer followed by a stability-window debouncer.
// The debounced output only follows the synchronized input once the two
// have disagreed for DB_CYCLES consecutive cycles.
module myniosiicpu_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_db
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchronizer, count disagreement, commit at window end.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;   // counter returns to 0 on the committing edge
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; keys idle high, so synchronizer and output reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db = db_q;

endmodule

// File: rtl/myniosiicpu_key_pio.sv
// Key PIO slave: per-key debounce, falling-edge capture, interrupt mask and
// a four-word Avalon-MM register map with zero-wait-state reads.
module myniosiicpu_key_pio
  import myniosiicpu_pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev_q, db_prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] fall;
  logic             wr;
  logic             unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_key
      myniosiicpu_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .key_in  (in_port[gi]),
        .key_db  (db[gi])
      );
    end
  endgenerate

  assign wr           = chipselect & ~write_n;
  assign fall         = db_prev_q & ~db;
  assign unused_wdata = ^writedata;

  // Register updates; a capture wins over a same-cycle write-1-to-clear.
  always_comb begin
    db_prev_d = db;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    edgecap_d = edgecap_d | fall;
  end

  // Register state; history resets to idle-high so reset never looks like a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_q <= '1;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      db_prev_q <= db_prev_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Read mux: purely from address, chipselect is not involved.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(db);
      ADDR_IRQMASK: readdata = 32'(irqmask_q);
      ADDR_EDGECAP: readdata = 32'(edgecap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_myniosiicpu_key_pio.sv
// Directed bench for the key PIO with a 4-cycle debounce window.
module tb_myniosiicpu_key_pio;
  import myniosiicpu_pio_pkg::*;

  localparam int WIDTH = 4;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int vectors    = 0;
  int miscompares = 0;

  myniosiicpu_key_pio #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // One-cycle write; returns 1 time unit after the capturing edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = ADDR_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    #2;
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    rd(ADDR_DATA,    32'hF, "rst_data");
    rd(ADDR_RSVD,    32'h0, "rst_rsvd");
    rd(ADDR_IRQMASK, 32'h0, "rst_mask");
    rd(ADDR_EDGECAP, 32'h0, "rst_edgecap");
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Clean step on key 0: debounced fall after 6 edges, capture on the 7th
    in_port = 4'hE;
    repeat (5) tick();
    rd(ADDR_DATA, 32'hF, "step_data_e5");
    tick();
    rd(ADDR_DATA,    32'hE, "step_data_e6");
    rd(ADDR_EDGECAP, 32'h0, "step_cap_e6");
    tick();
    rd(ADDR_EDGECAP, 32'h1, "step_cap_e7");
    chk("step_irq_masked", {31'b0, irq}, 32'h0);
    rd(ADDR_DATA, 32'hE, "step_data_e7");

    // Mask enables irq; W1C clears the capture and drops irq
    wr(ADDR_IRQMASK, 32'h1);
    chk("mask_irq_on", {31'b0, irq}, 32'h1);
    rd(ADDR_IRQMASK, 32'h1, "mask_read");
    wr(ADDR_EDGECAP, 32'h1);
    rd(ADDR_EDGECAP, 32'h0, "w1c_cap");
    chk("w1c_irq_off", {31'b0, irq}, 32'h0);

    // Glitch on key 1 shorter than the window
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (10) tick();
    rd(ADDR_DATA,    32'hE, "glitch_data");
    rd(ADDR_EDGECAP, 32'h0, "glitch_cap");

    // Capture of key 1 collides with a W1C of the same bit
    in_port = 4'hC;
    repeat (6) tick();
    rd(ADDR_EDGECAP, 32'h0, "coll_pre");
    wr(ADDR_EDGECAP, 32'h2);
    rd(ADDR_EDGECAP, 32'h2, "coll_cap");
    chk("coll_irq_masked", {31'b0, irq}, 32'h0);
    wr(ADDR_EDGECAP, 32'h1);
    rd(ADDR_EDGECAP, 32'h2, "w1c_other_bit");
    wr(ADDR_IRQMASK, 32'h3);
    chk("mask3_irq", {31'b0, irq}, 32'h1);
    wr(ADDR_DATA, 32'h0);
    rd(ADDR_DATA, 32'hC, "data_write_ignored");
    wr(ADDR_RSVD, 32'hF);
    rd(ADDR_RSVD, 32'h0, "rsvd_write_ignored");
    wr(ADDR_EDGECAP, 32'hF);
    rd(ADDR_EDGECAP, 32'h0, "cap_clear_all");

    // Release keys: rising edges are not captured
    in_port = 4'hF;
    repeat (10) tick();
    rd(ADDR_DATA,    32'hF, "rise_data");
    rd(ADDR_EDGECAP, 32'h0, "rise_cap");

    // Reset mid-count on key 2
    in_port = 4'hB;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    rd(ADDR_IRQMASK, 32'h0, "midrst_mask");
    rd(ADDR_DATA,    32'hF, "midrst_data");
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    in_port = 4'hF;
    repeat (10) tick();
    rd(ADDR_DATA,    32'hF, "postrst_short_data");
    rd(ADDR_EDGECAP, 32'h0, "postrst_short_cap");

    // Key 2 held low for the full window after reset
    in_port = 4'hB;
    repeat (6) tick();
    rd(ADDR_DATA,    32'hB, "hold_data");
    rd(ADDR_EDGECAP, 32'h0, "hold_cap_e6");
    tick();
    rd(ADDR_EDGECAP, 32'h4, "hold_cap_e7");
    chk("hold_irq_masked", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/myniosiicpu_key_pio.md
MYNIOSIICPU_KEY_PIO -- requirements
Module: myniosiicpu_key_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of key inputs.
REQ-002 SHALL have parameter DB_CYCLES, default 500000: debounce stability window in clk cycles (10 ms at 50 MHz).
REQ-003 SHALL have clock clk and reset reset_n; reset_n is asynchronous, active-low.
REQ-004 Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: async active-low reset.
- address, input, 2: Avalon-MM word address.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- in_port, input, WIDTH: raw asynchronous keys, active-low, idle high.
- readdata, output, 32: read data, zero wait states.
- irq, output, 1: level interrupt, active-high.

Function
REQ-005 Register map: 0 = DATA (RO); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (RW); 3 = EDGECAP (read; write-1-to-clear).
REQ-006 Input sync: each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-007 Debounce counter, per bit:
- counts up while synchronized value differs from debounced value; clears when equal.
- debounced bit SHALL take the synchronized value on the edge where the counter reaches DB_CYCLES-1, and the counter SHALL clear then.
REQ-008 Counter width SHALL be $clog2(DB_CYCLES+1); saturation and wrap SHALL NOT occur.
REQ-009 Glitch rule: a synchronized pulse shorter than DB_CYCLES cycles SHALL NOT change the debounced bit.
REQ-010 Fall detect: a debounced 1->0 transition on bit i SHALL set EDGECAP[i] on the following clock edge; 0->1 transitions SHALL NOT set it.
REQ-011 Latency: in_port fall to EDGECAP set SHALL be exactly DB_CYCLES+3 clk cycles for a clean step.
REQ-012 EDGECAP clear: a write (chipselect=1, write_n=0, address=3) SHALL clear EDGECAP bits where writedata[i]=1 and leave the other bits unchanged.
REQ-013 Set/clear collision: a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-014 IRQMASK write: a write at address 2 SHALL load writedata[WIDTH-1:0] into IRQMASK.
REQ-015 Write at address 0 SHALL be ignored.
REQ-016 readdata SHALL be combinational from address, independent of chipselect:
- DATA returns the debounced vector, zero-extended.
- IRQMASK and EDGECAP return their values, zero-extended.
- address 1 returns 0.
REQ-017 irq SHALL equal |(EDGECAP & IRQMASK), driven combinationally from registers.
REQ-018 IRQMASK change SHALL affect irq in the same cycle the register updates; masked EDGECAP bits SHALL still latch.

Reset
REQ-019 On reset_n low, asynchronously:
- synchronizer flops and debounced bits SHALL go to all-ones (idle).
- debounce counters, IRQMASK and EDGECAP SHALL go to 0.
- irq SHALL be 0.
REQ-020 After reset release with in_port held low: the debounced bit SHALL fall after DB_CYCLES+2 cycles and set EDGECAP once.
REQ-021 Reset asserted mid-debounce SHALL discard the count; no edge from before reset SHALL be captured.

Structure
REQ-022 Shared package myniosiicpu_pio_pkg SHALL hold the address constants ADDR_DATA=0, ADDR_IRQMASK=2 and ADDR_EDGECAP=3.
REQ-023 Per-bit sync+debounce SHALL be sub-module myniosiicpu_debounce (parameter DB_CYCLES), instantiated WIDTH times via generate.
REQ-024 Register file, edge detect and irq logic SHALL live in the top level.

Verification (bench DB_CYCLES=4, WIDTH=4)
REQ-025 Reset, no stimulus, read addresses 0/1/2/3 -> 0x0000000F, 0, 0, 0; irq=0.
REQ-026 Drive in_port=4'b1110 as a clean step -> EDGECAP=0x1 exactly 7 cycles later; irq stays 0 (mask 0); DATA reads 0xE.
REQ-027 Write IRQMASK=0x1 after REQ-026 -> irq=1; write EDGECAP 0x1 -> EDGECAP=0 and irq=0 next cycle.
REQ-028 Pulse in_port[1] low for 3 synchronized cycles -> DATA and EDGECAP unchanged.
REQ-029 Write 0x2 to EDGECAP in the same cycle bit 1 is set by a debounced fall -> EDGECAP[1]=1.
REQ-030 Assert reset_n for 1 cycle mid-count on bit 2 -> all registers at reset values; no EDGECAP[2] set unless in_port[2] remains low for the full window after release.
